scoreboard_regfile: RTL

//   Parametrised multi-read-port register file: configurable width/depth/port count, optional hardwired-zero R0, write-to-read bypass.

---
 rtl/scoreboard_regfile_pkg.sv | 12 +
 rtl/scoreboard_regfile_read_port.sv | 34 +++
 rtl/scoreboard_regfile.sv | 97 +++++++++
 3 files changed

// File: rtl/scoreboard_regfile_pkg.sv
// Shared defaults and clear-engine state encoding for the scoreboarded register file.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/scoreboard_regfile_read_port.sv
// One read port: address mux, R0 gating, write-to-read bypass and busy flag.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]                        addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]       regs,
    input  logic [(1<<ADDR_W)-1:0]                   pend,
    input  logic                                     idle,
    input  logic                                     wr_en,
    input  logic [ADDR_W-1:0]                        wr_addr,
    input  logic [DATA_W-1:0]                        wr_data,
    output logic [DATA_W-1:0]                        data,
    output logic                                     busy
);

    always_comb begin
        data = regs[addr];
        busy = pend[addr];
        if (ZERO_REG != 0 && addr == '0) begin
            data = '0;
            busy = 1'b0;
        end else if (BYPASS != 0 && idle && wr_en && wr_addr == addr) begin
            // forwarded write clears pending, so the operand is usable now
            data = wr_data;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-port register file with per-register pending scoreboard and a sequenced bulk-clear engine.
module scoreboard_regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned ADDR_W   = ADDR_W_DEF,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0]             pend;
    clr_state_t                   state;
    logic [ADDR_W-1:0]            cnt;
    logic                         wr_ok;
    logic                         rsv_ok;

    assign wr_ok  = wr_en  && !(ZERO_REG != 0 && wr_addr  == '0);
    assign rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            regs     <= '0;
            pend     <= '0;
            state    <= IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        regs[wr_addr] <= wr_data;
                        pend[wr_addr] <= 1'b0;
                    end
                    // reserve after write: a same-cycle new producer keeps the register pending
                    if (rsv_ok)
                        pend[rsv_addr] <= 1'b1;
                    if (clr_req) begin
                        state    <= CLEAR;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    regs[cnt] <= '0;
                    pend[cnt] <= 1'b0;
                    cnt       <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .pend    (pend),
            .idle    (state == IDLE),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .data    (rd_data[i*DATA_W +: DATA_W]),
            .busy    (rd_busy[i])
        );
    end

endmodule
